// File: rtl/if_id_decode_stage_if.sv
// Fetch-side and decode-side signals of the IF/ID stage, bundled so the
// stage, its fetch source and its immediate-generator consumer share one view.
//   slave  : the IF/ID stage (takes fetch word, produces registered decode)
//   master : the fetch/consumer side that drives stimulus and reads decode
//   inst_in/pc_in/in_valid/in_ready : fetch handshake
//   stall/nop                       : hold / flush controls
//   out_valid..illegal              : registered instruction and decode
interface if_id_decode_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic [31:0]         inst_in;
  logic [PC_WIDTH-1:0] pc_in;
  logic                in_valid;
  logic                in_ready;
  logic                stall;
  logic                nop;
  logic                out_valid;
  logic [24:0]         inst_out;
  logic [PC_WIDTH-1:0] pc_out;
  logic [4:0]          rd;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic                i_type;
  logic                s_type;
  logic                sb_type;
  logic                u_type;
  logic                uj_type;
  logic                illegal;

  modport slave (
    input  inst_in, pc_in, in_valid, stall, nop,
    output in_ready, out_valid, inst_out, pc_out, rd, rs1, rs2,
           i_type, s_type, sb_type, u_type, uj_type, illegal
  );

  modport master (
    output inst_in, pc_in, in_valid, stall, nop,
    input  in_ready, out_valid, inst_out, pc_out, rd, rs1, rs2,
           i_type, s_type, sb_type, u_type, uj_type, illegal
  );
endinterface

// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register with immediate-type decode.
// Captures a fetched instruction + PC on a valid/ready handshake and presents
// instruction bits [31:7], register fields and a one-hot immediate-type select
// to the immediate generator. Supports stall (hold) and nop (flush to bubble),
// with a one-cycle hold-off after a flush.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : if_id_decode_stage_if.slave (fetch handshake, stall/nop, decode out)
module if_id_decode_stage #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_id_decode_stage_if.slave   bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

  // type vector order: {uj, u, sb, s, i}
  localparam logic [4:0] T_I  = 5'b00001;
  localparam logic [4:0] T_S  = 5'b00010;
  localparam logic [4:0] T_SB = 5'b00100;
  localparam logic [4:0] T_U  = 5'b01000;
  localparam logic [4:0] T_UJ = 5'b10000;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_in_ready;
  logic                w_capture;
  logic                w_bubble;
  logic [4:0]          w_type;
  logic                w_illegal;

  logic [24:0]         r_inst;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_valid;
  logic [4:0]          r_type;
  logic                r_illegal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state and load control. nop wins over stall and in_valid; HOLD
  // keeps reloading the bubble and ignores every control input.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.nop) begin
          w_state_nxt = ST_HOLD;
          w_bubble    = 1'b1;
        end else if (!bus.stall) begin
          w_in_ready = 1'b1;
          if (bus.in_valid) w_capture = 1'b1;
          else              w_bubble  = 1'b1;
        end
      end
      ST_HOLD: begin
        w_state_nxt = ST_RUN;
        w_bubble    = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Opcode decode of the incoming word; registered alongside it.
  always_comb begin
    w_type    = 5'b00000;
    w_illegal = 1'b0;
    case (bus.inst_in[6:0])
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: w_type = T_I;
      7'b0100011:             w_type = T_S;
      7'b1100011:             w_type = T_SB;
      7'b0110111, 7'b0010111: w_type = T_U;
      7'b1101111:             w_type = T_UJ;
      7'b0110011:             w_type = 5'b00000;  // R-type: no immediate
      default:                w_illegal = 1'b1;
    endcase
  end

  // Pipeline register. A bubble keeps the PC; only real captures move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst    <= NOP_INST[31:7];
      r_pc      <= '0;
      r_valid   <= 1'b0;
      r_type    <= '0;
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_inst    <= bus.inst_in[31:7];
      r_pc      <= bus.pc_in;
      r_valid   <= 1'b1;
      r_type    <= w_type;
      r_illegal <= w_illegal;
    end else if (w_bubble) begin
      r_inst    <= NOP_INST[31:7];
      r_valid   <= 1'b0;
      r_type    <= '0;
      r_illegal <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.inst_out  = r_inst;
  assign bus.pc_out    = r_pc;
  // Field slices relative to bit 7 of the full instruction
  assign bus.rd        = r_inst[4:0];
  assign bus.rs1       = r_inst[12:8];
  assign bus.rs2       = r_inst[17:13];
  assign bus.i_type    = r_type[0];
  assign bus.s_type    = r_type[1];
  assign bus.sb_type   = r_type[2];
  assign bus.u_type    = r_type[3];
  assign bus.uj_type   = r_type[4];
  assign bus.illegal   = r_illegal;

endmodule

// File: doc/if_id_decode_stage.md
Name: if_id_decode_stage

Overview:
- IF/ID pipeline register plus immediate-type decoder.
- Sits directly upstream of the immediate generator.
- Captures a 32-bit fetched instruction and its PC with a valid/ready handshake.
- Presents instruction bits [31:7] and a one-hot immediate-type select (i_type, s_type, sb_type, u_type, uj_type) for the generator to consume; supports stall and nop (flush) with a one-cycle post-flush hold-off.

Parameters:
- PC_WIDTH, 32, width of program counter carried alongside instruction
- NOP_INST, 32'h00000013, bubble encoding (addi x0,x0,0) loaded on reset/flush

Ports:
- clk  input  1  processor clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- inst_in  input  32  fetched instruction
- pc_in  input  PC_WIDTH  PC of inst_in
- in_valid  input  1  fetch presents a valid instruction
- in_ready  output  1  stage accepts inst_in this cycle
- stall  input  1  hold current contents (downstream hazard)
- nop  input  1  flush: replace contents with bubble
- out_valid  output  1  registered instruction is real (not bubble)
- inst_out  output  25  registered instruction bits [31:7]
- pc_out  output  PC_WIDTH  registered PC
- rd  output  5  instr[11:7]
- rs1  output  5  instr[19:15]
- rs2  output  5  instr[24:20]
- i_type  output  1  I immediate (load, op-imm, jalr, system)
- s_type  output  1  S immediate
- sb_type  output  1  SB immediate
- u_type  output  1  U immediate (lui, auipc)
- uj_type  output  1  UJ immediate (jal)
- illegal  output  1  unrecognised opcode on a valid instruction

Behaviour:
- Reset (async on rst_n low, released synchronously in effect):
  - instruction register = NOP_INST, so inst_out = 25'h0
  - pc_out = 0, out_valid = 0, all type flags = 0, illegal = 0
  - state = RUN
- State machine, two states:
  - RUN -> HOLD on nop=1.
  - HOLD -> RUN unconditionally next cycle.
- in_ready = (state==RUN) && !stall && !nop. Combinational; no dependency on in_valid.
- Capture, latency 1 cycle: when in_valid && in_ready at an edge, the register loads inst_in/pc_in and out_valid=1.
- RUN, in_ready=1 but in_valid=0: load bubble (NOP_INST, out_valid=0, flags 0). pc_out holds.
- stall=1 (and nop=0): register, pc_out, out_valid and flags all hold; in_ready=0.
- nop=1:
  - Priority over stall and in_valid.
  - Next edge loads bubble, out_valid=0, flags 0, illegal=0.
  - The fetch word offered that cycle is not taken.
- HOLD: in_ready=0 for exactly one cycle. The register keeps the bubble regardless of in_valid/stall/nop. A nop asserted in HOLD is ignored; state returns to RUN.
- Decode is registered with the instruction, so flags align with inst_out. Flags are computed only for captured real instructions, by opcode = inst_in[6:0]:
  - 0000011, 0010011, 1100111, 1110011 -> i_type
  - 0100011 -> s_type
  - 1100011 -> sb_type
  - 0110111, 0010111 -> u_type
  - 1101111 -> uj_type
  - 0110011 (R-type) -> all flags 0, illegal=0
  - any other opcode, including bits[1:0]!=2'b11 -> all flags 0, illegal=1
- At most one type flag high in any cycle (one-hot or zero).
- rd/rs1/rs2 are slices of the registered instruction; they read 0 for bubble.
- Reset mid-HOLD or mid-stall returns to the reset values above and state RUN.

Test Plan:
- Reset: rst_n low for 3 cycles, release -> out_valid=0, inst_out=0, flags 0, in_ready=1 (stall=0, nop=0).
- Load capture: inst_in=32'h00812283 (lw x5,8(x2)), pc_in=32'h100, in_valid=1 -> next cycle i_type=1, inst_out=25'h0010245, rd=5, rs1=2, pc_out=32'h100, out_valid=1.
- Back-to-back stream, one instruction per cycle with no bubbles:
  - 32'h00512623 (sw) -> s_type=1, rs2=5, rs1=2
  - 32'h12345537 (lui x10) -> u_type=1, rd=10
  - 32'h008000EF (jal x1) -> uj_type=1, rd=1
- Stall: capture sw, then stall=1 for 3 cycles with in_valid=1 and a new word -> outputs frozen on sw, in_ready=0 throughout.
- Flush: nop=1 for one cycle while in_valid=1 -> next cycle out_valid=0, inst_out=0; in_ready=0 for one cycle; next word 32'h0000006F is accepted one cycle later with uj_type=1.
- Illegal and R-type:
  - 32'hFFFFFFFF -> illegal=1, all flags 0, out_valid=1
  - 32'h002081B3 (add) -> illegal=0, all flags 0
  - assert rst_n low during HOLD -> reset values, in_ready=1 after release.
